// File: rtl/id_ex_interlock.sv
// Decode-to-execute stage: drives register-file read selects, interlocks on RAW
// hazards against in-flight EX/MEM writers, and registers the ID/EX payload.
module id_ex_interlock #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [2:0]        if_rs,
    input  logic              if_rs_used,
    input  logic [2:0]        if_rt,
    input  logic              if_rt_used,
    input  logic [2:0]        if_rd,
    input  logic              if_rd_wr,
    input  logic [CTRL_W-1:0] if_ctrl,
    input  logic              flush,
    output logic [2:0]        read1regsel,
    output logic [2:0]        read2regsel,
    input  logic [15:0]       read1data,
    input  logic [15:0]       read2data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [2:0]        ex_rd,
    output logic              ex_rd_wr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       ex_a,
    output logic [15:0]       ex_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_ex_valid;
    logic [2:0]        r_ex_rd;
    logic              r_ex_rd_wr;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [15:0]       r_ex_a;
    logic [15:0]       r_ex_b;
    logic              r_mem_v;
    logic              r_mem_wr;
    logic [2:0]        r_mem_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_stall;

    // A source conflicts if either the EX or MEM occupant will still write it.
    assign w_rs_hit = (r_ex_valid & r_ex_rd_wr & (r_ex_rd == if_rs)) |
                      (r_mem_v & r_mem_wr & (r_mem_rd == if_rs));
    assign w_rt_hit = (r_ex_valid & r_ex_rd_wr & (r_ex_rd == if_rt)) |
                      (r_mem_v & r_mem_wr & (r_mem_rd == if_rt));
    assign w_hazard = if_valid & ((if_rs_used & w_rs_hit) | (if_rt_used & w_rt_hit));
    assign w_stall  = w_hazard & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_rd_wr  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_mem_v     <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_mem_v  <= r_ex_valid;
            r_mem_wr <= r_ex_rd_wr;
            r_mem_rd <= r_ex_rd;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            // Flush, bubble and idle all leave a fully cleared ID/EX register.
            if (flush || w_hazard || !if_valid) begin
                r_ex_valid <= 1'b0;
                r_ex_rd    <= '0;
                r_ex_rd_wr <= 1'b0;
                r_ex_ctrl  <= '0;
                r_ex_a     <= '0;
                r_ex_b     <= '0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_rd    <= if_rd;
                r_ex_rd_wr <= if_rd_wr;
                r_ex_ctrl  <= if_ctrl;
                r_ex_a     <= read1data;
                r_ex_b     <= read2data;
            end
        end
    end

    assign read1regsel = if_rs;
    assign read2regsel = if_rt;
    assign id_stall    = w_stall;
    assign ex_valid    = r_ex_valid;
    assign ex_rd       = r_ex_rd;
    assign ex_rd_wr    = r_ex_rd_wr;
    assign ex_ctrl     = r_ex_ctrl;
    assign ex_a        = r_ex_a;
    assign ex_b        = r_ex_b;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_interlock.sv
// Self-checking bench for id_ex_interlock: directed hazard scenarios followed by
// randomized traffic, compared against an in-flight-writer list model.
module tb_id_ex_interlock;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [2:0]  if_rs, if_rt, if_rd;
    logic        if_rs_used, if_rt_used, if_rd_wr;
    logic [7:0]  if_ctrl;
    logic        flush;
    logic [15:0] read1data, read2data;

    logic [2:0]  read1regsel, read2regsel, ex_rd;
    logic        id_stall, ex_valid, ex_rd_wr;
    logic [7:0]  ex_ctrl;
    logic [15:0] ex_a, ex_b, stall_cnt;

    logic [2:0]  s_r1, s_r2, s_rd;
    logic        s_stall, s_v, s_wr;
    logic [7:0]  s_ctrl;
    logic [15:0] s_a, s_b;
    logic [3:0]  stall_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_interlock #(.CTRL_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_rs(if_rs), .if_rs_used(if_rs_used),
        .if_rt(if_rt), .if_rt_used(if_rt_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr),
        .if_ctrl(if_ctrl), .flush(flush), .read1regsel(read1regsel), .read2regsel(read2regsel),
        .read1data(read1data), .read2data(read2data), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .stall_cnt(stall_cnt)
    );

    id_ex_interlock #(.CTRL_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_rs(if_rs), .if_rs_used(if_rs_used),
        .if_rt(if_rt), .if_rt_used(if_rt_used), .if_rd(if_rd), .if_rd_wr(if_rd_wr),
        .if_ctrl(if_ctrl), .flush(flush), .read1regsel(s_r1), .read2regsel(s_r2),
        .read1data(read1data), .read2data(read2data), .id_stall(s_stall), .ex_valid(s_v),
        .ex_rd(s_rd), .ex_rd_wr(s_wr), .ex_ctrl(s_ctrl), .ex_a(s_a), .ex_b(s_b),
        .stall_cnt(stall_cnt4)
    );

    // Reference model: writers still ahead of decode, [0] = one ahead, [1] = two ahead.
    logic        pend_v[2];
    logic        pend_wr[2];
    logic [2:0]  pend_rd[2];
    logic        m_ex_v, m_ex_wr;
    logic [2:0]  m_ex_rd;
    logic [7:0]  m_ex_ctrl;
    logic [15:0] m_ex_a, m_ex_b;
    int          m_cnt16, m_cnt4;
    logic        exp_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            pend_v[k] = 1'b0; pend_wr[k] = 1'b0; pend_rd[k] = '0;
        end
        m_ex_v = 0; m_ex_wr = 0; m_ex_rd = '0; m_ex_ctrl = '0; m_ex_a = '0; m_ex_b = '0;
        m_cnt16 = 0; m_cnt4 = 0;
    endtask

    // One clock: comb checks at negedge, model update at posedge, state checks #1 later.
    task automatic tick();
        logic hz, accept;
        @(negedge clk);
        hz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (pend_v[k] && pend_wr[k] &&
                ((if_rs_used && pend_rd[k] == if_rs) || (if_rt_used && pend_rd[k] == if_rt)))
                hz = 1'b1;
        end
        hz = hz & if_valid;
        exp_stall = hz & ~flush;
        chk("id_stall", id_stall, exp_stall);
        chk("read1regsel", read1regsel, if_rs);
        chk("read2regsel", read2regsel, if_rt);
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            if (exp_stall) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            accept = if_valid & ~flush & ~hz;
            pend_v[1] = pend_v[0]; pend_wr[1] = pend_wr[0]; pend_rd[1] = pend_rd[0];
            pend_v[0] = accept; pend_wr[0] = accept & if_rd_wr; pend_rd[0] = accept ? if_rd : 3'd0;
            m_ex_v    = accept;
            m_ex_wr   = accept & if_rd_wr;
            m_ex_rd   = accept ? if_rd : 3'd0;
            m_ex_ctrl = accept ? if_ctrl : 8'd0;
            m_ex_a    = accept ? read1data : 16'd0;
            m_ex_b    = accept ? read2data : 16'd0;
        end
        #1;
        chk("ex_valid", ex_valid, m_ex_v);
        chk("ex_rd", ex_rd, m_ex_rd);
        chk("ex_rd_wr", ex_rd_wr, m_ex_wr);
        chk("ex_ctrl", ex_ctrl, m_ex_ctrl);
        chk("ex_a", ex_a, m_ex_a);
        chk("ex_b", ex_b, m_ex_b);
        chk("stall_cnt", stall_cnt, m_cnt16);
        chk("stall_cnt4", stall_cnt4, m_cnt4);
    endtask

    task automatic set_in(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                          input logic wr, input logic [15:0] d1, input logic [15:0] d2);
        rst = 1'b1; flush = 1'b0; if_valid = v;
        if_rs = rs; if_rs_used = rsu; if_rt = rt; if_rt_used = rtu;
        if_rd = rd; if_rd_wr = wr; if_ctrl = 8'($urandom); read1data = d1; read2data = d2;
    endtask

    // Present one instruction and hold it while stalled; returns the stall count.
    task automatic issue(input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic [2:0] rd, input logic wr,
                         input logic [15:0] d1, input logic [15:0] d2, output int stalls);
        logic done;
        set_in(1'b1, rs, rsu, rt, rtu, rd, wr, d1, d2);
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            tick();
            if (exp_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int k = 0; k < cycles; k++) tick();
        rst = 1'b1;
    endtask

    initial begin
        int st;
        int saved;
        logic held;
        set_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 16'h1111, 16'h2222);
        rst = 1'b0;
        model_clear();
        exp_stall = 1'b0;
        @(posedge clk);
        #1;

        // Reset with a valid instruction presented.
        do_reset(2);
        chk("t1_ex_valid", ex_valid, 1'b0);
        chk("t1_stall_cnt", stall_cnt, 16'd0);
        tick();
        chk("t1_id_stall", id_stall, 1'b0);

        // Dependence on the immediately preceding writer: two stall cycles.
        do_reset(1);
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 16'h0, 16'h0, st);
        issue(3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 16'h1234, 16'h0, st);
        chk("t2_stalls", st, 2);
        chk("t2_ex_valid", ex_valid, 1'b1);
        chk("t2_ex_a", ex_a, 16'h1234);
        chk("t2_stall_cnt", stall_cnt, 16'd2);

        // Dependence two ahead: one stall cycle.
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 16'h0, 16'h0, st);
        issue(3'd7, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, st);
        issue(3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 16'h0, 16'hBEEF, st);
        chk("t3_stalls", st, 1);
        chk("t3_ex_b", ex_b, 16'hBEEF);

        // Matching register on an unused source never stalls.
        saved = int'(stall_cnt);
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 16'h0, 16'h0, st);
        issue(3'd2, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 16'h0, 16'h0, st);
        chk("t4_stalls", st, 0);
        chk("t4_stall_cnt", stall_cnt, saved);

        // Flush in the first would-be stall cycle.
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        tick(); tick();
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 16'h0, 16'h0, st);
        saved = int'(stall_cnt);
        set_in(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 16'h5555, 16'h0);
        flush = 1'b1;
        tick();
        chk("t5_id_stall", id_stall, 1'b0);
        chk("t5_ex_valid", ex_valid, 1'b0);
        chk("t5_stall_cnt", stall_cnt, saved);
        flush = 1'b0;

        // 20 stall cycles saturate the 4-bit counter.
        do_reset(1);
        for (int p = 0; p < 10; p++) begin
            issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 16'h0, 16'h0, st);
            issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, st);
        end
        chk("t6_cnt4_sat", stall_cnt4, 4'd15);
        chk("t6_cnt16", stall_cnt, 16'd20);

        // Randomized traffic; stalled instructions are held as fetch would.
        held = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!held)
                set_in(($urandom_range(0, 9) != 0), 3'($urandom), 1'($urandom), 3'($urandom),
                       1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            else begin
                read1data = 16'($urandom);
                read2data = 16'($urandom);
            end
            flush = ($urandom_range(0, 99) < 8);
            rst   = ($urandom_range(0, 99) >= 2);
            tick();
            held = exp_stall & rst;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
